calc_seq_ctrl: RTL and testbench
================================

CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, giving the cycles between operand drive and result capture (legal 1..15).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream byte valid.
REQ-006 in_ready  output  1  block accepts byte this cycle.
REQ-007 in_data  input  8  operand/opcode byte stream, order A, B, OP.
REQ-008 flush  input  1  synchronous abort of the current transaction.
REQ-009 calc_a  output  8  operand A to the calculator stage.
REQ-010 calc_b  output  8  operand B to the calculator stage.
REQ-011 calc_op  output  3  opcode to the calculator stage.
REQ-012 calc_out  input  16  calculator result.
REQ-013 calc_carry  input  1  calculator carry flag.
REQ-014 res_valid  output  1  result available downstream.
REQ-015 res_ready  input  1  downstream accepts result.
REQ-016 res_data  output  16  registered result.
REQ-017 res_carry  output  1  registered carry.
REQ-018 res_zero  output  1  registered zero flag.
REQ-019 res_err  output  2  bit0 = opcode byte bits [7:3] nonzero; bit1 = divide by zero.
REQ-020 busy  output  1  high in any state other than S_A.

Function
REQ-021 FSM states SHALL be S_A, S_B, S_OP, S_EXEC, S_OUT; in_ready = 1 only in S_A/S_B/S_OP.
REQ-022 A byte SHALL transfer only when in_valid and in_ready are both 1. Transfers: S_A->S_B loads calc_a; S_B->S_OP loads calc_b; S_OP->S_EXEC loads calc_op = in_data[2:0] and latches res_err[0] = |in_data[7:3].
REQ-023 With no transfer, the FSM SHALL hold its state, and calc_a/calc_b/calc_op SHALL hold their values.
REQ-024 S_EXEC SHALL load a counter with SETTLE_CYCLES and decrement it each cycle; it SHALL capture on the cycle the counter reaches 1, then enter S_OUT.
REQ-025 Total latency SHALL be SETTLE_CYCLES cycles from the OP transfer edge to res_valid = 1.
REQ-026 Capture SHALL set res_data = calc_out, except for opcode 3'b011 with calc_b == 0, which SHALL set res_data = 16'hFFFF and res_err[1] = 1.
REQ-027 res_carry SHALL equal calc_carry for opcodes 3'b000/3'b001, and SHALL be 0 otherwise.
REQ-028 res_zero SHALL be computed locally as (captured res_data == 0); calc_zero is not an input.
REQ-029 In S_OUT, res_valid SHALL be 1, and res_data/flags/err SHALL stay stable until res_ready = 1.
REQ-030 The handshake SHALL complete in the cycle where res_valid & res_ready; the next state is S_A, res_valid drops, and res_* keep their last value.
REQ-031 calc_a/calc_b/calc_op SHALL remain stable from the OP transfer until S_OUT exits.
REQ-032 flush = 1 in any state SHALL return the FSM to S_A next cycle, clear res_valid and res_err, and discard partial operands. flush SHALL take priority over a simultaneous in or res handshake, and no transfer is counted.
REQ-033 in_valid in S_EXEC/S_OUT SHALL be ignored, with no byte consumed.

Reset
REQ-034 rst_n = 0 SHALL immediately force: state S_A, in_ready 1, busy 0, res_valid 0, calc_a 0, calc_b 0, calc_op 0, res_data 0, res_carry 0, res_zero 0, res_err 0, counter 0.
REQ-035 A reset asserted mid-transaction (any state) SHALL abandon the transaction, and no result is ever presented for it.
REQ-036 After rst_n deasserts, the first byte SHALL be accepted on the first rising edge with in_valid = 1.

Verification
REQ-037 Bytes 0xC8, 0x64, 0x00 with a model returning calc_out = 0x012C and carry = 1 -> after 1 cycle res_valid = 1, res_data = 0x012C, res_carry = 1, res_zero = 0, res_err = 0.
REQ-038 Bytes 0x05, 0x00, 0x03 -> res_data = 0xFFFF, res_err = 2'b10, res_carry = 0.
REQ-039 Bytes 0x07, 0x03, 0x0A -> calc_op = 3'b010, res_err[0] = 1, res_carry = 0; with calc_out = 0 the response is res_zero = 1.
REQ-040 Hold res_ready = 0 for 5 cycles in S_OUT with in_valid = 1 -> res_* stable, in_ready = 0, no byte consumed; res_ready = 1 -> state S_A next cycle.
REQ-041 SETTLE_CYCLES = 3: pulse rst_n low during S_EXEC -> all outputs reach their reset values asynchronously and res_valid never rises; also assert flush in S_B -> state S_A next cycle, and the next byte loads calc_a.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: sequences A/B/OP bytes to a calculator stage and registers its result for downstream.
module calc_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        flush,
  output logic [7:0]  calc_a,
  output logic [7:0]  calc_b,
  output logic [2:0]  calc_op,
  input  logic [15:0] calc_out,
  input  logic        calc_carry,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_carry,
  output logic        res_zero,
  output logic [1:0]  res_err,
  output logic        busy
);
  typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_OUT} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic in_fire, res_fire, cap, div0;
  assign in_ready  = state == S_A || state == S_B || state == S_OP;
  assign res_valid = state == S_OUT;
  assign busy      = state != S_A;
  assign in_fire   = in_valid & in_ready & ~flush;
  assign res_fire  = res_valid & res_ready & ~flush;
  assign cap       = state == S_EXEC && cnt <= 4'd1 && !flush;
  assign div0      = calc_op == 3'b011 && calc_b == 8'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_A;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = S_A;
    else if (in_fire) state_nxt = state == S_A ? S_B : state == S_B ? S_OP : S_EXEC;
    else if (cap) state_nxt = S_OUT;
    else if (res_fire) state_nxt = S_A;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      calc_a    <= '0;
      calc_b    <= '0;
      calc_op   <= '0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
      res_err   <= '0;
      cnt       <= '0;
    end else if (flush) begin
      calc_a  <= '0;
      calc_b  <= '0;
      calc_op <= '0;
      res_err <= '0;
      cnt     <= '0;
    end else begin
      if (in_fire && state == S_A) calc_a <= in_data;
      if (in_fire && state == S_B) calc_b <= in_data;
      if (in_fire && state == S_OP) begin
        calc_op <= in_data[2:0];
        res_err <= {1'b0, |in_data[7:3]};
        cnt     <= 4'(SETTLE_CYCLES);
      end
      if (state == S_EXEC) cnt <= cap ? 4'd0 : cnt - 4'd1;
      // Divide by zero overrides whatever the calculator produced
      if (cap) begin
        res_data   <= div0 ? 16'hFFFF : calc_out;
        res_carry  <= (calc_op == 3'b000 || calc_op == 3'b001) & calc_carry;
        res_zero   <= !div0 && calc_out == 16'd0;
        res_err[1] <= div0;
      end
    end
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: directed scoreboard bench for calc_seq_ctrl at SETTLE_CYCLES 1 and 3.
module tb_calc_seq_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [7:0] in_data;
  logic [15:0] calc_out;
  logic calc_carry;
  logic rst_n, in_valid, flush, res_ready, in_ready, res_valid, res_carry, res_zero, busy;
  logic [7:0] calc_a, calc_b;
  logic [2:0] calc_op;
  logic [15:0] res_data;
  logic [1:0] res_err;
  logic rst_n3, in_valid3, flush3, res_ready3, in_ready3, res_valid3, res_carry3, res_zero3, busy3;
  logic [7:0] calc_a3, calc_b3;
  logic [2:0] calc_op3;
  logic [15:0] res_data3;
  logic [1:0] res_err3;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic [15:0] d; logic c; logic z; logic [1:0] e;} res_t;
  res_t q[$];
  res_t q3[$];
  calc_seq_ctrl #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .calc_a(calc_a), .calc_b(calc_b), .calc_op(calc_op), .calc_out(calc_out),
    .calc_carry(calc_carry), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_zero(res_zero), .res_err(res_err), .busy(busy));
  calc_seq_ctrl #(.SETTLE_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n3), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data),
    .flush(flush3), .calc_a(calc_a3), .calc_b(calc_b3), .calc_op(calc_op3), .calc_out(calc_out),
    .calc_carry(calc_carry), .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
    .res_carry(res_carry3), .res_zero(res_zero3), .res_err(res_err3), .busy(busy3));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic res_t model(input logic [7:0] b, input logic [7:0] op, input logic [15:0] co, input logic cc);
    res_t r;
    logic dz;
    dz = op[2:0] == 3'b011 && b == 8'd0;
    r.d = dz ? 16'hFFFF : co;
    r.c = op[2:0] <= 3'd1 ? cc : 1'b0;
    r.z = r.d == 16'd0;
    r.e = {dz, |op[7:3]};
    return r;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input bit s3, input logic [7:0] b);
    in_data = b;
    if (s3) in_valid3 = 1'b1;
    else in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    in_valid3 = 1'b0;
  endtask
  task automatic txn(input bit s3, input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                     input logic [15:0] co, input logic cc);
    calc_out = co;
    calc_carry = cc;
    if (s3) q3.push_back(model(b, op, co, cc));
    else q.push_back(model(b, op, co, cc));
    send(s3, a);
    send(s3, b);
    send(s3, op);
  endtask
  task automatic collect(input bit s3, input int lat);
    int n;
    res_t e, o;
    n = 0;
    while (!(s3 ? res_valid3 : res_valid) && n < 40) begin
      tick;
      n++;
    end
    chk(s3 ? "latency3" : "latency", n, lat);
    if (s3) begin
      chk("sb_depth3", q3.size(), 1);
      e = q3.pop_front();
      o = {res_data3, res_carry3, res_zero3, res_err3};
    end else begin
      chk("sb_depth", q.size(), 1);
      e = q.pop_front();
      o = {res_data, res_carry, res_zero, res_err};
    end
    chk(s3 ? "result3" : "result", o, e);
  endtask
  task automatic accept(input bit s3);
    if (s3) res_ready3 = 1'b1;
    else res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    res_ready3 = 1'b0;
    chk(s3 ? "handshake3" : "handshake", s3 ? {res_valid3, busy3} : {res_valid, busy}, 0);
  endtask
  task automatic chk_reset(input bit s3);
    if (s3) begin
      chk("rst_ctl3", {in_ready3, busy3, res_valid3, calc_op3, res_carry3, res_zero3, res_err3}, 32'h200);
      chk("rst_dat3", {calc_a3, calc_b3, res_data3}, 0);
    end else begin
      chk("rst_ctl", {in_ready, busy, res_valid, calc_op, res_carry, res_zero, res_err}, 32'h200);
      chk("rst_dat", {calc_a, calc_b, res_data}, 0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    res_t held;
    rst_n = 1'b0; rst_n3 = 1'b0;
    in_valid = 1'b0; in_valid3 = 1'b0; flush = 1'b0; flush3 = 1'b0;
    res_ready = 1'b0; res_ready3 = 1'b0;
    in_data = '0; calc_out = '0; calc_carry = 1'b0;
    #3;
    chk_reset(0);
    chk_reset(1);
    tick;
    rst_n = 1'b1; rst_n3 = 1'b1;
    txn(0, 8'hC8, 8'h64, 8'h00, 16'h012C, 1'b1);
    chk("ops_loaded", {calc_a, calc_b, calc_op}, {8'hC8, 8'h64, 3'b000});
    chk("exec_flags", {busy, in_ready, res_valid}, 3'b100);
    collect(0, 1);
    accept(0);
    chk("res_kept", {res_data, res_carry}, {16'h012C, 1'b1});
    txn(0, 8'h05, 8'h00, 8'h03, 16'h1234, 1'b1);
    collect(0, 1);
    accept(0);
    txn(0, 8'h07, 8'h03, 8'h0A, 16'h0000, 1'b1);
    chk("op_trunc", calc_op, 3'b010);
    collect(0, 1);
    held = {res_data, res_carry, res_zero, res_err};
    in_valid = 1'b1;
    in_data = 8'h99;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("hold_res", {res_data, res_carry, res_zero, res_err}, held);
      chk("hold_ctl", {res_valid, in_ready, calc_a}, {1'b1, 1'b0, 8'h07});
    end
    accept(0);
    in_valid = 1'b0;
    chk("no_consume", {calc_a, in_ready}, {8'h07, 1'b1});
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_err", {res_err, res_valid}, 0);
    for (int i = 0; i < 4; i++) begin
      txn(0, 8'($urandom), 8'($urandom_range(1, 255)), 8'($urandom_range(0, 7)), 16'($urandom), 1'($urandom));
      collect(0, 1);
      accept(0);
    end
    txn(1, 8'h10, 8'h20, 8'h01, 16'h0030, 1'b1);
    collect(1, 3);
    accept(1);
    calc_out = 16'h0033;
    send(1, 8'h11);
    send(1, 8'h22);
    send(1, 8'h00);
    tick;
    chk("in_exec3", {busy3, res_valid3}, 2'b10);
    #2;
    rst_n3 = 1'b0;
    #1;
    chk_reset(1);
    tick;
    rst_n3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("no_result3", res_valid3, 0);
    end
    send(1, 8'h33);
    chk("sb_state3", {busy3, calc_a3}, {1'b1, 8'h33});
    flush3 = 1'b1;
    in_valid3 = 1'b1;
    in_data = 8'h44;
    tick;
    flush3 = 1'b0;
    in_valid3 = 1'b0;
    chk("flush_sb3", {busy3, in_ready3, res_valid3, res_err3}, 5'b01000);
    send(1, 8'h5A);
    chk("reload_a3", {busy3, calc_a3}, {1'b1, 8'h5A});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
